// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding and pipeline-register (stage) indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    localparam int NUM_STAGES = 4;
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the ID instruction reads a register that the
// load currently in EX has not yet produced.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu_hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu_hazard = ex_mem_read && (ex_rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush generation, memory
// wait and debug halt/drain FSM, and stall/flush performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_modify_pc,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             halt_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               halt_ack_q, halt_ack_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic       mem_stall;
    logic       lu_hazard;
    logic       pc_en_c;
    logic       redirect_taken;
    stage_vec_t en_vec;
    stage_vec_t flush_vec;

    assign mem_stall = mem_req && !mem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hazard   (lu_hazard)
    );

    // A redirect seen during a memory stall needs no storage: EX is frozen,
    // so ex_modify_pc is still asserted in the cycle mem_ready arrives.
    always_comb begin
        en_vec         = '1;
        flush_vec      = '0;
        pc_en_c        = 1'b1;
        redirect_taken = 1'b0;
        if (state_q == ST_HALTED) begin
            en_vec    = '0;
            flush_vec = '1;
            pc_en_c   = 1'b0;
        end else begin
            if (mem_stall) begin
                pc_en_c                = 1'b0;
                en_vec[STG_IF_ID]      = 1'b0;
                en_vec[STG_ID_EX]      = 1'b0;
                en_vec[STG_EX_MEM]     = 1'b0;
                flush_vec[STG_MEM_WB]  = 1'b1;
            end else if (ex_modify_pc) begin
                redirect_taken         = 1'b1;
                flush_vec[STG_IF_ID]   = 1'b1;
                flush_vec[STG_ID_EX]   = 1'b1;
            end else if (lu_hazard) begin
                pc_en_c                = 1'b0;
                en_vec[STG_IF_ID]      = 1'b0;
                flush_vec[STG_ID_EX]   = 1'b1;
            end
            // Draining: fetch only bubbles, but still latch a redirect target
            if (state_q == ST_DRAIN) begin
                en_vec[STG_IF_ID]    = 1'b1;
                flush_vec[STG_IF_ID] = 1'b1;
                pc_en_c              = redirect_taken;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
                if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else if (mem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else if (!mem_stall) begin
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        halt_ack_d    = (state_q == ST_HALTED);
        mem_timeout_d = mem_timeout_q ||
                        ((state_q == ST_MEM_WAIT) && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)));
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if ((state_q != ST_HALTED) && !pc_en_c) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_taken) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            halt_ack_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            halt_ack_q    <= halt_ack_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Reset forces every pipeline register to hold a bubble
    assign pc_en        = rst_n && pc_en_c;
    assign if_id_en     = rst_n && en_vec[STG_IF_ID];
    assign id_ex_en     = rst_n && en_vec[STG_ID_EX];
    assign ex_mem_en    = rst_n && en_vec[STG_EX_MEM];
    assign mem_wb_en    = rst_n && en_vec[STG_MEM_WB];
    assign if_id_flush  = !rst_n || flush_vec[STG_IF_ID];
    assign id_ex_flush  = !rst_n || flush_vec[STG_ID_EX];
    assign ex_mem_flush = !rst_n || flush_vec[STG_EX_MEM];
    assign mem_wb_flush = !rst_n || flush_vec[STG_MEM_WB];

    assign halt_ack    = halt_ack_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int CNT_W = 8;
    localparam int TO    = 4;
    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_modify_pc;
    logic       mem_req, mem_ready, halt_req;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
    logic       halt_ack, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0] obsVec;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit m_wait, m_drain, m_halted, m_to, m_ack;
    int m_dc, m_wc, m_stalls, m_flushes;

    pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_modify_pc(ex_modify_pc),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
        .halt_ack(halt_ack), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign obsVec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                         input bit mread, input bit modpc, input bit mreq, input bit mrdy,
                         input bit halt);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = 5'(rd); ex_mem_read = mread; ex_modify_pc = modpc;
        mem_req = mreq; mem_ready = mrdy; halt_req = halt;
    endtask

    // Which priority rule governs this cycle: 0 halted, 1 mem stall,
    // 2 redirect, 3 load-use, 4 free-running.
    function automatic int ruleNow();
        bit hz;
        hz = ex_mem_read && (int'(ex_rd) != 0) &&
             ((id_use_rs1 && int'(id_rs1) == int'(ex_rd)) ||
              (id_use_rs2 && int'(id_rs2) == int'(ex_rd)));
        if (m_halted) return 0;
        if (mem_req && !mem_ready) return 1;
        if (ex_modify_pc) return 2;
        if (hz) return 3;
        return 4;
    endfunction

    // {pc, en if/idex/exmem/memwb, flush if/idex/exmem/memwb}
    function automatic logic [8:0] ctrlFor(input int rule);
        logic [8:0] v;
        case (rule)
            0: v = 9'b0_0000_1111;
            1: v = 9'b0_0001_0001;
            2: v = 9'b1_1111_1100;
            3: v = 9'b0_0111_0100;
            default: v = 9'b1_1111_0000;
        endcase
        if (m_drain) begin
            v[8] = (rule == 2);
            v[7] = 1'b1;
            v[3] = 1'b1;
        end
        return v;
    endfunction

    task automatic modelReset();
        m_wait = 0; m_drain = 0; m_halted = 0; m_to = 0; m_ack = 0;
        m_dc = 0; m_wc = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic modelAdvance(input int rule, input bit pcExp);
        bit mstall;
        mstall = mem_req && !mem_ready;
        if (!m_halted && !pcExp) m_stalls = (m_stalls + 1) % (1 << CNT_W);
        if (rule == 2) m_flushes = (m_flushes + 1) % (1 << CNT_W);
        m_ack = m_halted;
        if (m_halted) begin
            if (!halt_req) m_halted = 0;
        end else if (m_drain) begin
            if (!halt_req) begin
                m_drain = 0; m_dc = 0;
            end else if (!mstall) begin
                m_dc++;
                if (m_dc == DRAIN) begin
                    m_drain = 0; m_halted = 1; m_dc = 0;
                end
            end
        end else begin
            if (m_wait) begin
                m_wc = (m_wc + 1 > TO) ? TO : m_wc + 1;
                if (m_wc == TO) m_to = 1;
            end
            if (halt_req) begin
                m_drain = 1; m_wait = 0; m_dc = 0;
            end else if (m_wait) begin
                if (mem_ready) m_wait = 0;
            end else if (mstall) begin
                m_wait = 1; m_wc = 0;
            end
        end
    endtask

    // One clock cycle with the inputs currently driven
    task automatic applyStimulus();
        int rule;
        logic [8:0] exp;
        #2;
        rule = ruleNow();
        exp  = ctrlFor(rule);
        checkOutput("ctrl", 32'(obsVec), 32'(exp));
        modelAdvance(rule, exp[8]);
        @(posedge clk);
        #1;
        checkOutput("halt_ack", 32'(halt_ack), 32'(m_ack));
        checkOutput("mem_timeout", 32'(mem_timeout), 32'(m_to));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        checkOutput("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'(obsVec), 32'h00F);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        checkOutput("rst_halt_ack", 32'(halt_ack), 32'h0);
        checkOutput("rst_timeout", 32'(mem_timeout), 32'h0);
        modelReset();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit hold;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #3;
        doReset();

        // load-use: exactly one bubble
        setIn(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        // load into x0: no dependency
        setIn(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("x0_stall_cnt", 32'(stall_cnt), 32'd1);
        // redirect beats load-use
        setIn(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        applyStimulus();
        checkOutput("redir_flush_cnt", 32'(flush_cnt), 32'd1);

        // memory wait holding a redirect, applied when data arrives
        for (int i = 0; i < 3; i++) begin
            setIn(1, 2, 1, 1, 3, 0, 1, 1, 0, 0);
            applyStimulus();
        end
        setIn(1, 2, 1, 1, 3, 0, 1, 1, 1, 0);
        applyStimulus();
        checkOutput("memwait_flush_cnt", 32'(flush_cnt), 32'd2);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();

        // timeout after MEM_TIMEOUT wait cycles, sticky
        for (int i = 0; i < 6; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            applyStimulus();
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("timeout_sticky", 32'(mem_timeout), 32'd1);

        // halt: one RUN cycle, four drain cycles, one HALTED cycle
        for (int i = 0; i < 6; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            applyStimulus();
        end
        checkOutput("halt_ack_set", 32'(halt_ack), 32'd1);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("halt_ack_clr", 32'(halt_ack), 32'd0);

        // halt with a two-cycle memory wait inside the drain
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 4) setIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            else                  setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            applyStimulus();
            if (i == 6) checkOutput("halt_ack_delayed", 32'(halt_ack), 32'd0);
        end
        checkOutput("halt_ack_late", 32'(halt_ack), 32'd1);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        applyStimulus();

        // reset while in MEM_WAIT
        setIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus();
        applyStimulus();
        #2;
        doReset();
        setIn(7, 0, 1, 0, 7, 1, 0, 0, 0, 0);
        applyStimulus();

        // random traffic
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) hold = !hold;
            setIn($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), hold);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
